// File: rtl/uart_pkg.sv
// Shared encodings and defaults for the UART receive/transmit path.
package uart_pkg;
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } rx_state_t;

    // Rounded clocks-per-bit for a given clock and baud rate.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    // 71.4 MHz (14 ns) clock at 115200 baud.
    localparam int DEFAULT_CLK_PER_BIT = baud_div(71_400_000, 115_200);
endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; a full FIFO still accepts a push when popped the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// Parametrised RS-232 receiver with start-glitch rejection, sticky error flags and an output FIFO.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = PAR_NONE,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          rx,
    input  logic                          err_clr,
    output logic [DATA_BITS-1:0]          data,
    output logic                          valid,
    input  logic                          ready,
    output logic                          changed,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   count
);
    localparam int CW = $clog2(CLK_PER_BIT);

    rx_state_t            state;
    logic                 rx_meta, rxs, rxs_d;
    logic [CW-1:0]        cnt;
    logic [3:0]           bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bad, frm_bad;

    logic tick, last_stop, frm_final, good, pop_ok, accept;
    logic fifo_full, fifo_empty;

    assign tick      = (cnt == CW'(CLK_PER_BIT - 1));
    assign last_stop = (state == S_STOP) && tick && (stop_idx == 1'(STOP_BITS - 1));
    // The final stop sample is folded in combinationally so the frame resolves on that same cycle.
    assign frm_final = frm_bad | ~rxs;
    assign good      = last_stop && !frm_final && !par_bad;
    assign pop_ok    = valid && ready;
    assign accept    = good && (!fifo_full || pop_ok);
    assign valid     = !fifo_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta    <= 1'b1;
            rxs        <= 1'b1;
            rxs_d      <= 1'b1;
            state      <= S_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            shreg      <= '0;
            par_bad    <= 1'b0;
            frm_bad    <= 1'b0;
            changed    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rxs        <= rx_meta;
            rxs_d      <= rxs;
            cnt        <= tick ? '0 : cnt + CW'(1);
            changed    <= accept;
            frame_err  <= (frame_err  & ~err_clr) | (last_stop & frm_final);
            parity_err <= (parity_err & ~err_clr) | (last_stop & par_bad);
            overrun    <= (overrun    & ~err_clr) | (good & ~accept);

            case (state)
                S_IDLE: begin
                    if (enable && rxs_d && !rxs) begin
                        state <= S_START;
                        cnt   <= CW'(CLK_PER_BIT / 2);
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (!rxs) begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                            par_bad <= 1'b0;
                            frm_bad <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        shreg   <= {rxs, shreg[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 4'd1;
                        if (bit_idx == 4'(DATA_BITS - 1)) begin
                            state    <= (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                            stop_idx <= 1'b0;
                        end
                    end
                end
                S_PARITY: begin
                    if (tick) begin
                        par_bad <= ((^shreg) ^ rxs) != (PARITY == PAR_ODD);
                        state   <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        if (!rxs) frm_bad <= 1'b1;
                        if (last_stop) state <= S_IDLE;
                        else           stop_idx <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .wdata (shreg),
        .pop   (pop_ok),
        .rdata (data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench: three receivers (8N1, 8E1, 8N2) at 8 clocks/bit with 4-entry FIFOs.
module tb_uart_rx_fifo;
    localparam int CPB = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b1;
    logic err_clr = 1'b0;
    logic [2:0] rx = 3'b111;
    logic [2:0] ready = 3'b111;
    logic [2:0] valid, changed, frame_err, parity_err, overrun;
    logic [2:0][7:0] data;
    logic [2:0][2:0] count;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    int vectors = 0;
    int miscompares = 0;
    int chg [3] = '{0, 0, 0};

    initial forever #5 clk = ~clk;

    uart_rx_fifo #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_n1 (
        .clk(clk), .reset(reset), .enable(enable), .rx(rx[0]), .err_clr(err_clr),
        .data(data[0]), .valid(valid[0]), .ready(ready[0]), .changed(changed[0]),
        .frame_err(frame_err[0]), .parity_err(parity_err[0]), .overrun(overrun[0]), .count(count[0]));
    uart_rx_fifo #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_e1 (
        .clk(clk), .reset(reset), .enable(enable), .rx(rx[1]), .err_clr(err_clr),
        .data(data[1]), .valid(valid[1]), .ready(ready[1]), .changed(changed[1]),
        .frame_err(frame_err[1]), .parity_err(parity_err[1]), .overrun(overrun[1]), .count(count[1]));
    uart_rx_fifo #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_n2 (
        .clk(clk), .reset(reset), .enable(enable), .rx(rx[2]), .err_clr(err_clr),
        .data(data[2]), .valid(valid[2]), .ready(ready[2]), .changed(changed[2]),
        .frame_err(frame_err[2]), .parity_err(parity_err[2]), .overrun(overrun[2]), .count(count[2]));

    task automatic chk(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    task automatic sb_pop(input int i, output bit ok, output logic [7:0] e);
        ok = 1'b1;
        e  = 8'h00;
        case (i)
            0: if (q0.size() > 0) e = q0.pop_front(); else ok = 1'b0;
            1: if (q1.size() > 0) e = q1.pop_front(); else ok = 1'b0;
            default: if (q2.size() > 0) e = q2.pop_front(); else ok = 1'b0;
        endcase
    endtask

    // Monitor: a pop happens at the next posedge whenever valid && ready here.
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                bit ok;
                logic [7:0] e;
                if (changed[i]) chg[i]++;
                if (valid[i] && ready[i]) begin
                    sb_pop(i, ok, e);
                    if (ok) begin
                        chk($sformatf("pop_data_dut%0d", i), int'(data[i]), int'(e));
                    end else begin
                        vectors++;
                        miscompares++;
                        $display("FAIL pop_unexpected_dut%0d: got data 0x%0h, expected no output", i, data[i]);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input int i, input logic b);
        rx[i] = b;
        tick(CPB);
    endtask

    task automatic send_frame(input int i, input logic [7:0] d, input bit has_par,
                              input logic pbit, input int nstop, input logic stop2);
        drive_bit(i, 1'b0);
        for (int k = 0; k < 8; k++) drive_bit(i, d[k]);
        if (has_par) drive_bit(i, pbit);
        drive_bit(i, 1'b1);
        if (nstop == 2) drive_bit(i, stop2);
        rx[i] = 1'b1;
    endtask

    initial begin
        logic [7:0] b;
        tick(3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_valid_dut%0d", i), int'(valid[i]), 0);
            chk($sformatf("rst_count_dut%0d", i), int'(count[i]), 0);
            chk($sformatf("rst_data_dut%0d", i), int'(data[i]), 0);
            chk($sformatf("rst_flags_dut%0d", i),
                int'({frame_err[i], parity_err[i], overrun[i], changed[i]}), 0);
        end
        reset = 1'b0;
        tick(2 * CPB);

        // 8N1 0xA5 with ready held high
        q0.push_back(8'hA5);
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1, 1'b1);
        tick(2 * CPB);
        chk("n1_changed", chg[0], 1);
        chk("n1_count", int'(count[0]), 0);
        chk("n1_flags", int'({frame_err[0], parity_err[0], overrun[0]}), 0);

        // 8E1: good parity then bad parity
        q1.push_back(8'h03);
        send_frame(1, 8'h03, 1'b1, 1'b0, 1, 1'b1);
        send_frame(1, 8'h03, 1'b1, 1'b1, 1, 1'b1);
        tick(2 * CPB);
        chk("e1_parity_err", int'(parity_err[1]), 1);
        chk("e1_changed", chg[1], 1);
        chk("e1_count", int'(count[1]), 0);
        chk("e1_frame_err", int'(frame_err[1]), 0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("e1_err_clr", int'(parity_err[1]), 0);

        // 8N2 with second stop bit low, then a clean frame
        send_frame(2, 8'hC3, 1'b0, 1'b0, 2, 1'b0);
        tick(2 * CPB);
        chk("n2_frame_err", int'(frame_err[2]), 1);
        chk("n2_count", int'(count[2]), 0);
        chk("n2_no_changed", chg[2], 0);
        q2.push_back(8'h5A);
        send_frame(2, 8'h5A, 1'b0, 1'b0, 1, 1'b1);
        tick(3 * CPB);
        chk("n2_changed", chg[2], 1);
        chk("n2_count_after", int'(count[2]), 0);

        // Start-bit glitch of 3 clocks
        rx[0] = 1'b0;
        tick(3);
        rx[0] = 1'b1;
        tick(3 * CPB);
        chk("glitch_count", int'(count[0]), 0);
        chk("glitch_flags", int'({frame_err[0], parity_err[0], overrun[0]}), 0);
        chk("glitch_changed", chg[0], 1);

        // Overrun: five back-to-back frames into a 4-deep FIFO, no pops
        ready[0] = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            b = 8'(k * 17);
            if (k <= 4) q0.push_back(b);
            send_frame(0, b, 1'b0, 1'b0, 1, 1'b1);
        end
        tick(2 * CPB);
        chk("ovr_count", int'(count[0]), 4);
        chk("ovr_flag", int'(overrun[0]), 1);
        chk("ovr_valid", int'(valid[0]), 1);
        chk("ovr_head", int'(data[0]), 8'h11);
        chk("ovr_changed", chg[0], 5);
        ready[0] = 1'b1;
        tick(10);
        chk("drain_count", int'(count[0]), 0);
        chk("drain_queue", q0.size(), 0);

        // Reset in the middle of data bit 4, with a byte waiting in the FIFO
        ready[0] = 1'b0;
        q0.push_back(8'h66);
        send_frame(0, 8'h66, 1'b0, 1'b0, 1, 1'b1);
        tick(2 * CPB);
        chk("pre_rst_count", int'(count[0]), 1);
        b = 8'h81;
        drive_bit(0, 1'b0);
        for (int k = 0; k < 4; k++) drive_bit(0, b[k]);
        rx[0] = b[4];
        tick(CPB / 2);
        reset = 1'b1;
        q0.delete();
        tick(1);
        chk("mid_rst_valid", int'(valid[0]), 0);
        chk("mid_rst_count", int'(count[0]), 0);
        chk("mid_rst_data", int'(data[0]), 0);
        chk("mid_rst_flags", int'({frame_err[0], parity_err[0], overrun[0], changed[0]}), 0);
        reset = 1'b0;
        rx[0] = 1'b1;
        tick(4 * CPB);
        ready[0] = 1'b1;
        q0.push_back(8'h7E);
        send_frame(0, 8'h7E, 1'b0, 1'b0, 1, 1'b1);
        tick(3 * CPB);
        chk("post_rst_changed", chg[0], 7);
        chk("post_rst_count", int'(count[0]), 0);
        chk("post_rst_flags", int'({frame_err[0], parity_err[0], overrun[0]}), 0);
        chk("queues_empty", q0.size() + q1.size() + q2.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised successor to the i232c receiver, used in the end-to-end bench to decode the top's RS_TX and as an on-chip RS-232 input.
- Adds configurable data width, parity, stop bits and baud divisor.
- Adds start-bit glitch rejection, framing/parity/overrun detection and an output FIFO with valid/ready handshake.
- Keeps an i232c-compatible one-cycle `changed` strobe.

Parameters:
- CLK_PER_BIT, 620, clocks per bit (71.4 MHz / 115200), >= 4
- DATA_BITS, 8, payload bits per frame, 5..9, LSB first
- PARITY, 0, 0 none / 1 odd / 2 even
- STOP_BITS, 1, 1 or 2
- FIFO_DEPTH, 16, entries, power of two >= 2

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  when 0, no new frame starts; a frame in progress completes
- rx  in  1  serial input, idle high, asynchronous
- err_clr  in  1  clears sticky error flags
- data  out  DATA_BITS  FIFO head (first-word fall-through)
- valid  out  1  FIFO non-empty
- ready  in  1  consumer pop; pop occurs when valid && ready
- changed  out  1  one-cycle pulse per byte accepted into the FIFO
- frame_err  out  1  sticky: a stop bit sampled 0
- parity_err  out  1  sticky: parity mismatch
- overrun  out  1  sticky: good byte dropped because FIFO full
- count  out  clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: synchroniser regs = 1; FSM = IDLE; FIFO empty; outputs valid, changed, frame_err, parity_err, overrun, count = 0; data = 0.
- rx passes through a 2-FF synchroniser; all logic uses the synchronised value `rxs`. A falling edge on rxs is detected against the previous synchronised sample.
- Bit counter counts 0..CLK_PER_BIT-1. Sampling happens at counter terminal.
- IDLE: on `enable` && falling edge of rxs -> START, load counter for CLK_PER_BIT/2.
- START: at terminal, if rxs==0 -> DATA (bit index 0, full-bit counter). Otherwise -> IDLE (glitch; no flag).
- DATA: sample each bit into a shift register, LSB first. After DATA_BITS samples -> PARITY if PARITY!=0, else STOP.
- PARITY: sample and compare.
  - Odd mode: XOR(data, p) must be 1.
  - Even mode: XOR(data, p) must be 0.
  - Mismatch marks the frame bad.
- STOP: sample STOP_BITS bits. Any 0 marks framing error. After the last stop sample -> IDLE in the same cycle, so back-to-back frames are accepted.
- Frame result, on the cycle of the final stop sample:
  - Good frame: push into FIFO and pulse `changed`. valid/data reflect the byte on the next cycle, so latency from the last stop sample to valid is 1 clk.
  - Bad frame: byte discarded. parity_err and/or frame_err set next cycle. No push, no `changed`.
  - Good frame with FIFO full and no pop that cycle: byte dropped, overrun set, no `changed`.
  - Good frame with FIFO full and a pop that cycle: push accepted; count unchanged.
- Simultaneous push and pop on a non-full FIFO: count unchanged, pointers both advance.
- Pop with valid==0 is ignored.
- err_clr clears all three sticky flags. If a new error occurs in the same cycle, the set wins.
- enable dropped mid-frame: the frame finishes normally; IDLE then ignores edges until enable=1.
- reset asserted mid-frame: immediate return to reset state next edge; FIFO contents are lost.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. count distinguishes full from empty.

Decomposition:
- Shared package `uart_pkg` holds:
  - parity encodings PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2;
  - FSM state constants S_IDLE, S_START, S_DATA, S_PARITY, S_STOP;
  - the default CLK_PER_BIT for a 14 ns clock at 115200 baud.
- One sub-module is natural: `sync_fifo`, parametrised by WIDTH and DEPTH, with push/pop/full/empty/count, FWFT output and synchronous active-high reset. It is reusable for the transmitter.

Test Plan:
- Bench setup: CLK_PER_BIT=8, FIFO_DEPTH=4 unless stated.
- 8N1 byte 0xA5 with ready=1 -> changed pulses once; data=0xA5 while valid; count returns to 0; no error flags.
- 8E1 frames 0x03 with correct parity bit 0, then 0x03 with parity bit 1 -> first byte delivered; second byte dropped and parity_err=1; err_clr -> parity_err=0.
- 8N2, second stop bit driven 0 -> frame_err=1, count=0. Then 0x5A in 8N1 immediately after -> 0x5A delivered.
- rx low pulse of 3 clocks in IDLE -> FSM returns to IDLE; count=0; no flags.
- ready=0, five back-to-back good frames 0x11..0x55 -> count=4, overrun=1. Then popping drains 0x11, 0x22, 0x33, 0x44 in order.
- reset asserted at DATA bit 4 of a frame -> all outputs 0 next cycle. A following clean frame 0x7E is received correctly.
